// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, CTRL layout and shared types for apb_timer
package apb_timer_pkg;

  localparam logic [4:0] CTRL_OFS   = 5'h00;
  localparam logic [4:0] LOAD_OFS   = 5'h04;
  localparam logic [4:0] VALUE_OFS  = 5'h08;
  localparam logic [4:0] STATUS_OFS = 5'h0C;

  localparam int EN_BIT       = 0;
  localparam int RELOAD_BIT   = 1;
  localparam int IE_BIT       = 2;
  localparam int PRESCALE_LSB = 8;
  localparam int PRESCALE_MSB = 15;

  // CTRL flag bits; the prescale field is held separately at its parameterised width.
  typedef struct packed {
    logic ie;
    logic reload;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/apb_timer_if.sv
// rtl/apb_timer_if.sv - APB slave port of the timer (no pready/pslverr)
interface apb_timer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_timer_prescaler.sv
// rtl/apb_timer_prescaler.sv - counts 0..prescale and pulses tick on the terminal count
module apb_timer_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] prescale_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (!en_i || clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - zero-wait APB timer: prescaled 32-bit down-counter, sticky expiry, maskable irq
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic        hclk,
  input  logic        hreset,
  apb_timer_if.slave  bus,
  output logic        irq
);

  ctrl_t                     ctrl_q, ctrl_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0]     load_q, load_d;
  logic [DATA_WIDTH-1:0]     value_q, value_d;
  logic                      exp_q, exp_d;
  logic                      irq_q, irq_d;
  logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0]     ctrl_rd;

  logic [4:0] ofs;
  logic       wr_en, rd_setup, wr_ctrl, wr_load, wr_status;
  logic       tick, expire;

  assign ofs       = {bus.paddr[4:2], 2'b00};
  assign wr_en     = bus.psel && bus.penable && bus.pwrite;
  assign rd_setup  = bus.psel && !bus.penable && !bus.pwrite;
  assign wr_ctrl   = wr_en && (ofs == CTRL_OFS);
  assign wr_load   = wr_en && (ofs == LOAD_OFS);
  assign wr_status = wr_en && (ofs == STATUS_OFS);
  assign expire    = tick && (value_q == '0);

  apb_timer_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk_i      (hclk),
    .rst_i      (hreset),
    .en_i       (ctrl_q.en),
    .clr_i      (wr_load),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  always_comb begin
    ctrl_rd                                   = '0;
    ctrl_rd[EN_BIT]                           = ctrl_q.en;
    ctrl_rd[RELOAD_BIT]                       = ctrl_q.reload;
    ctrl_rd[IE_BIT]                           = ctrl_q.ie;
    ctrl_rd[PRESCALE_LSB +: PRESCALE_WIDTH]   = prescale_q;
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    value_d    = value_q;
    exp_d      = exp_q;
    prdata_d   = prdata_q;
    irq_d      = exp_q && ctrl_q.ie;

    if (tick) begin
      if (value_q != '0) begin
        value_d = value_q - DATA_WIDTH'(1);
      end else if (ctrl_q.reload) begin
        value_d = load_q;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end

    // Later assignments win: expiry over W1C, LOAD write over tick, CTRL write over auto-clear.
    if (wr_status && bus.pwdata[0]) exp_d = 1'b0;
    if (expire)                     exp_d = 1'b1;

    if (wr_load) begin
      load_d  = bus.pwdata;
      value_d = bus.pwdata;
    end

    if (wr_ctrl) begin
      ctrl_d.en     = bus.pwdata[EN_BIT];
      ctrl_d.reload = bus.pwdata[RELOAD_BIT];
      ctrl_d.ie     = bus.pwdata[IE_BIT];
      prescale_d    = bus.pwdata[PRESCALE_LSB +: PRESCALE_WIDTH];
    end

    if (rd_setup) begin
      case (ofs)
        CTRL_OFS:   prdata_d = ctrl_rd;
        LOAD_OFS:   prdata_d = load_q;
        VALUE_OFS:  prdata_d = value_q;
        STATUS_OFS: prdata_d = {{(DATA_WIDTH-1){1'b0}}, exp_q};
        default:    prdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      load_q     <= '0;
      value_q    <= '0;
      exp_q      <= 1'b0;
      irq_q      <= 1'b0;
      prdata_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      value_q    <= value_d;
      exp_q      <= exp_d;
      irq_q      <= irq_d;
      prdata_q   <= prdata_d;
    end
  end

  assign bus.prdata = prdata_q;
  assign irq        = irq_q;

endmodule
